gen_scheduler: RTL and testbench
================================

// Module: gen_scheduler
// PURPOSE
//  Sequences generation updates of the Life engine. A programmable tick divider
//  runs off clock_in; each tick, or each single-step request, issues one gen_start
//  pulse to the cell-update engine. The block then waits for gen_done before
//  issuing another. Sits between the board controls (run/step/speed) and the engine.
//  Also counts completed generations and flags ticks lost while the engine is busy.
// PARAMETERS
//  BASE_DIV  12_500_000  tick period in clocks at speed 0; must be >= 2**(2**SPEED_W-1)
//  SPEED_W   3           width of speed select
//  GEN_W     16          width of generation counter
// PORTS
//  clock_in   in   1        system clock
//  reset      in   1        asynchronous, active-low reset
//  run        in   1        level; 1 = free-run generations at the selected speed
//  step       in   1        1-cycle pulse (pre-debounced); request one generation
//  speed      in   SPEED_W  tick period = BASE_DIV >> speed (0 = slowest)
//  clear_ovr  in   1        1-cycle pulse; clears overrun
//  gen_done   in   1        engine finished the current generation (pulse)
//  gen_start  out  1        1-cycle pulse; engine begins one generation
//  busy       out  1        1 while a generation is in flight (state BUSY)
//  gen_count  out  GEN_W    number of completed generations
//  overrun    out  1        sticky; a tick was dropped
// BEHAVIOUR
//  Reset: reset is asynchronous, active-low; clock is clock_in. Reset is allowed
//   at any time, including mid-generation. Every output and register returns to 0:
//   gen_start, busy, gen_count, overrun, tick counter, pending, state = IDLE.
//  Tick divider:
//   - tick counter runs only while run=1.
//   - Period P = BASE_DIV >> speed. Counter counts 0..P-1; tick is a 1-cycle
//     internal strobe on the cycle the counter = P-1, and the counter wraps to 0.
//   - run=0: counter held at 0, so the first tick arrives P cycles after run rises.
//   - speed differs from its registered copy: counter forced to 0 that cycle,
//     no tick that cycle.
//  Pending flag (one-deep request queue):
//   - Set by a tick, or by step (step is honoured whether run is 0 or 1).
//   - Set while already set: overrun <= 1 and the extra request is lost.
//   - Cleared when the request is consumed (IDLE -> BUSY).
//   - run falling edge clears pending. A generation already in flight still
//     completes.
//  FSM (2 states):
//   - IDLE: if pending, or a request arrives this cycle:
//     gen_start <= 1 for exactly 1 cycle, busy <= 1, go to BUSY, consume request.
//     Latency from a step or tick strobe at cycle N to gen_start high is N+1.
//   - BUSY: gen_done=1 -> gen_count <= gen_count+1 (wraps 2**GEN_W-1 -> 0),
//     busy <= 0, go to IDLE. gen_done is accepted from the same cycle gen_start
//     is high onward.
//     The earliest next gen_start is 1 cycle after return to IDLE, so there are
//     >= 2 cycles between gen_start pulses.
//   - gen_done while in IDLE is ignored: no count change.
//  Simultaneous events:
//   - tick and step in the same cycle with pending=0: a single request,
//     no overrun.
//   - clear_ovr together with a new overrun event: set wins (overrun stays 1).
//   - gen_done together with a new request in BUSY: the request goes to pending
//     and is issued from IDLE next cycle.
// TESTING (sim: BASE_DIV=16, SPEED_W=3, GEN_W=4; engine model returns gen_done
//          3 cycles after gen_start unless stated)
//  1 Reset mid-BUSY: pulse reset low -> gen_start=busy=overrun=0, gen_count=0 at
//    once; no gen_start until a new request arrives.
//  2 run=1, speed=0: gen_start every 16 clocks, the first 17 clocks after run
//    rises; speed=2 -> every 4 clocks; gen_count counts 1,2,3...
//  3 run=0, step pulse at cycle 10 -> gen_start at cycle 11 only, busy on cycles
//    11..14, gen_count=1; gen_done injected in IDLE -> gen_count stays 1.
//  4 Engine latency 40 cycles, speed=1 (P=8): tick sets pending, the next tick
//    sets overrun=1, gen_start reissued right after gen_done; clear_ovr -> 0.
//  5 gen_count wrap: 16 generations -> gen_count returns to 0, overrun stays 0.
//  6 Simultaneous tick and step with pending=0 -> exactly one gen_start, overrun=0;
//    speed change mid-count -> next tick exactly P cycles later.

Source files
------------

// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - generation sequencer: tick divider, one-deep request queue, start/done handshake
module gen_scheduler #(
    parameter int BASE_DIV = 12_500_000,
    parameter int SPEED_W  = 3,
    parameter int GEN_W    = 16
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [SPEED_W-1:0] speed,
    input  logic               clear_ovr,
    input  logic               gen_done,
    output logic               gen_start,
    output logic               busy,
    output logic [GEN_W-1:0]   gen_count,
    output logic               overrun
);

    localparam int CW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      period_m1;
    logic [SPEED_W-1:0] speed_q;
    logic               run_q;
    logic               pending;
    logic [0:0]         state;

    logic counting;
    logic speed_chg;
    logic at_end;
    logic tick;
    logic req;
    logic pend_live;
    logic ovr_evt;

    assign period_m1 = CW'((BASE_DIV >> speed) - 1);

    // Counting needs run seen high for a full cycle, so the first tick lands P cycles after run rises
    assign counting  = run & run_q;
    assign speed_chg = (speed != speed_q);
    assign at_end    = (cnt == period_m1);
    assign tick      = counting & ~speed_chg & at_end;
    assign req       = tick | step;
    assign pend_live = pending & ~(run_q & ~run);
    assign ovr_evt   = req & pend_live;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            speed_q <= '0;
            run_q   <= 1'b0;
        end else begin
            speed_q <= speed;
            run_q   <= run;
            if (!counting || speed_chg || at_end)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            gen_start <= 1'b0;
            busy      <= 1'b0;
            pending   <= 1'b0;
            gen_count <= '0;
        end else begin
            gen_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    pending <= 1'b0;
                    if (pend_live || req) begin
                        gen_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_BUSY;
                    end
                end
                default: begin
                    // A request arriving with gen_done waits in pending and issues from IDLE
                    pending <= pend_live | req;
                    if (gen_done) begin
                        gen_count <= gen_count + 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset)
            overrun <= 1'b0;
        else if (ovr_evt)
            overrun <= 1'b1;
        else if (clear_ovr)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// tb/tb_gen_scheduler.sv - scoreboard bench for gen_scheduler with a fixed-latency engine model
module tb_gen_scheduler;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [2:0] speed;
    logic       clear_ovr;
    logic       gen_done;
    logic       gen_start;
    logic       busy;
    logic [3:0] gen_count;
    logic       overrun;

    gen_scheduler #(.BASE_DIV(16), .SPEED_W(3), .GEN_W(4)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .speed    (speed),
        .clear_ovr(clear_ovr),
        .gen_done (gen_done),
        .gen_start(gen_start),
        .busy     (busy),
        .gen_count(gen_count),
        .overrun  (overrun)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   lat   = 3;
    int   done_at = -1;
    logic inject = 1'b0;

    // Engine model: gen_done lat cycles after gen_start, plus forced pulses
    always @(negedge clock_in) if (gen_start) done_at = cyc + lat;

    always @(posedge clock_in) begin
        cyc = cyc + 1;
        #2;
        gen_done = (cyc == done_at) || inject;
    end

    always @(negedge clock_in) begin
        if (reset && gen_start) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL gen_start_unexpected: got start at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.cnt != int'(gen_count)) begin
                    bad++;
                    $display("FAIL gen_start: got cycle %0d count %0d, required cycle %0d count %0d",
                             cyc, gen_count, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic push(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    initial begin
        int c;
        int c1;
        int base;
        reset = 1'b0; run = 1'b0; step = 1'b0; speed = 3'd0;
        clear_ovr = 1'b0; gen_done = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_gen_start", gen_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        wait_to(cyc + 2);

        // Free run at speed 0 then speed 2
        c = cyc + 1;
        wait_to(c);
        lat = 3;
        run = 1'b1;
        push(c + 17, 0); push(c + 33, 1); push(c + 49, 2);
        wait_to(c + 55);
        run = 1'b0;
        speed = 3'd2;
        chk("run_spd0_count", gen_count, 3);
        c1 = c + 60;
        wait_to(c1);
        lat = 2;
        run = 1'b1;
        push(c1 + 5, 3); push(c1 + 9, 4); push(c1 + 13, 5);
        wait_to(c1 + 14);
        run = 1'b0;
        wait_to(c1 + 17);
        chk("run_spd2_count", gen_count, 6);

        // Single step with run low, then gen_done while idle
        lat = 3;
        c = cyc + 10;
        wait_to(c);
        step = 1'b1;
        push(c + 1, 6);
        wait_to(c + 1);
        step = 1'b0;
        chk("step_busy_first", busy, 1);
        wait_to(c + 4);
        chk("step_busy_last", busy, 1);
        wait_to(c + 5);
        chk("step_busy_drop", busy, 0);
        chk("step_count", gen_count, 7);
        wait_to(c + 7);
        inject = 1'b1;
        wait_to(c + 8);
        inject = 1'b0;
        wait_to(c + 10);
        chk("idle_done_ignored", gen_count, 7);

        // Slow engine: pending, overrun, clear racing set, run fall drops pending
        speed = 3'd1;
        c = cyc + 3;
        wait_to(c);
        lat = 40;
        run = 1'b1;
        push(c + 9, 7); push(c + 51, 8);
        wait_to(c + 17);
        chk("pending_no_ovr", overrun, 0);
        wait_to(c + 26);
        chk("ovr_set", overrun, 1);
        wait_to(c + 48);
        clear_ovr = 1'b1;
        wait_to(c + 49);
        clear_ovr = 1'b0;
        chk("ovr_set_beats_clear", overrun, 1);
        wait_to(c + 57);
        run = 1'b0;
        wait_to(c + 60);
        clear_ovr = 1'b1;
        wait_to(c + 61);
        clear_ovr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        chk("slow_busy", busy, 1);
        wait_to(c + 93);
        chk("slow_count", gen_count, 9);
        chk("run_fall_drops_pending", busy, 0);

        // Reset during BUSY with overrun set
        lat = 3;
        c = cyc + 2;
        wait_to(c);
        step = 1'b1;
        push(c + 1, 9);
        wait_to(c + 3);
        step = 1'b0;
        chk("pre_rst_overrun", overrun, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_gen_start", gen_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gen_count", gen_count, 0);
        chk("mid_rst_overrun", overrun, 0);
        done_at = -1;
        wait_to(c + 5);
        reset = 1'b1;
        wait_to(c + 15);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", gen_count, 0);

        // Counter wrap after 16 generations
        base = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            wait_to(base + 5 * i);
            if (i == 15) chk("count_15", gen_count, 15);
            step = 1'b1;
            push(base + 5 * i + 1, i);
            wait_to(base + 5 * i + 1);
            step = 1'b0;
        end
        wait_to(base + 82);
        chk("count_wrap", gen_count, 0);
        chk("wrap_overrun", overrun, 0);

        // Tick and step together, then speed change mid-count
        c = cyc + 3;
        wait_to(c);
        run = 1'b1;
        wait_to(c + 8);
        step = 1'b1;
        push(c + 9, 0);
        wait_to(c + 9);
        step = 1'b0;
        wait_to(c + 10);
        chk("tick_step_no_ovr", overrun, 0);
        push(c + 17, 1);
        wait_to(c + 20);
        speed = 3'd2;
        push(c + 25, 2);
        wait_to(c + 26);
        run = 1'b0;
        wait_to(c + 27);
        chk("spd_chg_overrun", overrun, 0);
        wait_to(c + 30);
        chk("spd_chg_count", gen_count, 3);

        wait_to(cyc + 5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
